multi_channel_watchdog: RTL

Parametrised, N-channel receiver watchdog with configurable error tolerance, reset pulse width, post-reset hold-off and a retry limit that latches a per-channel fault. Each channel watches one receiver's error flag and pulses that receiver's reset when the error persists. A channel that keeps failing is parked in FAULT instead of being reset forever. The block sits between the receiver error flags and the receiver reset inputs; the fault and aggregate outputs feed status registers.

---
 rtl/watchdog_pkg.sv | 29 ++
 rtl/watchdog_channel.sv | 124 ++++++++++++
 rtl/multi_channel_watchdog.sv | 63 ++++++
 3 files changed

// File: rtl/watchdog_pkg.sv
// Shared types and width helpers for the multi-channel receiver watchdog.
package watchdog_pkg;

    typedef enum logic [2:0] {
        OK      = 3'd0,
        ERR     = 3'd1,
        RESET   = 3'd2,
        HOLDOFF = 3'd3,
        FAULT   = 3'd4
    } wd_state_t;

    // Timer width: wide enough to hold the largest of the cycle parameters.
    function automatic int unsigned cnt_width(input int unsigned wait_c,
                                              input int unsigned reset_c,
                                              input int unsigned holdoff_c,
                                              input int unsigned stable_c);
        int unsigned m;
        m = wait_c;
        if (reset_c > m)   m = reset_c;
        if (holdoff_c > m) m = holdoff_c;
        if (stable_c > m)  m = stable_c;
        return $clog2(m + 1);
    endfunction

    function automatic int unsigned retry_width(input int unsigned max_retries);
        return (max_retries == 0) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/watchdog_channel.sv
// One watchdog channel: error tolerance timer, reset pulse, hold-off and retry/fault tracking.
module watchdog_channel
    import watchdog_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES    = 10000,
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned HOLDOFF_CYCLES = 1000,
    parameter int unsigned STABLE_CYCLES  = 100000,
    parameter int unsigned MAX_RETRIES    = 8
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic enable_i,
    input  logic error_i,
    input  logic clear_i,
    output logic reset_o,
    output logic fault_o
);

    localparam int unsigned CW = cnt_width(WAIT_CYCLES, RESET_CYCLES, HOLDOFF_CYCLES, STABLE_CYCLES);
    localparam int unsigned RW = retry_width(MAX_RETRIES);

    localparam logic [CW-1:0] WAIT_LAST  = CW'(WAIT_CYCLES - 32'd1);
    localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 32'd1);
    localparam logic [CW-1:0] HOLD_LAST  = (HOLDOFF_CYCLES == 0) ? '0 : CW'(HOLDOFF_CYCLES - 32'd1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRIES);

    wd_state_t     state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] stable;
    logic [RW-1:0] retries;
    logic [RW-1:0] retries_inc;

    assign retries_inc = (retries == RETRY_MAX) ? retries : retries + RW'(1);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state   <= RESET;
            cnt     <= '0;
            stable  <= '0;
            retries <= '0;
            reset_o <= 1'b1;
            fault_o <= 1'b0;
        end else if (!enable_i) begin
            // Disable wins over everything, truncating any reset pulse in flight.
            state   <= OK;
            cnt     <= '0;
            stable  <= '0;
            retries <= '0;
            reset_o <= 1'b0;
            fault_o <= 1'b0;
        end else begin
            case (state)
                OK: begin
                    if (error_i) begin
                        state  <= ERR;
                        cnt    <= '0;
                        stable <= '0;
                    end else if (stable != STABLE_MAX) begin
                        stable <= stable + CW'(1);
                        if (stable == STABLE_MAX - CW'(1)) retries <= '0;
                    end
                end
                ERR: begin
                    if (!error_i) begin
                        state <= OK;
                    end else if (cnt == WAIT_LAST) begin
                        state   <= RESET;
                        cnt     <= '0;
                        retries <= retries_inc;
                        reset_o <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESET: begin
                    if (cnt == RESET_LAST) begin
                        cnt     <= '0;
                        reset_o <= 1'b0;
                        if (MAX_RETRIES != 0 && retries == RETRY_MAX) begin
                            state   <= FAULT;
                            fault_o <= 1'b1;
                        end else if (HOLDOFF_CYCLES == 0) begin
                            state  <= OK;
                            stable <= '0;
                        end else begin
                            state <= HOLDOFF;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state  <= OK;
                        cnt    <= '0;
                        stable <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FAULT: begin
                    // Clear restarts with a fresh retry budget; this pulse counts as the first.
                    if (clear_i) begin
                        state   <= RESET;
                        cnt     <= '0;
                        retries <= RW'(1);
                        reset_o <= 1'b1;
                        fault_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= OK;
                    cnt     <= '0;
                    stable  <= '0;
                    reset_o <= 1'b0;
                    fault_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/multi_channel_watchdog.sv
// N independent receiver watchdog channels plus registered aggregate reset/fault flags.
module multi_channel_watchdog #(
    parameter int unsigned N_CHANNELS     = 4,
    parameter int unsigned WAIT_CYCLES    = 10000,
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned HOLDOFF_CYCLES = 1000,
    parameter int unsigned STABLE_CYCLES  = 100000,
    parameter int unsigned MAX_RETRIES    = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [N_CHANNELS-1:0] enable_i,
    input  logic [N_CHANNELS-1:0] error_i,
    input  logic [N_CHANNELS-1:0] clear_i,
    output logic [N_CHANNELS-1:0] reset_o,
    output logic [N_CHANNELS-1:0] fault_o,
    output logic                  any_reset_o,
    output logic                  any_fault_o
);

    if (N_CHANNELS < 1) begin : g_bad_n
        $fatal(1, "N_CHANNELS must be at least 1");
    end
    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $fatal(1, "WAIT_CYCLES must be at least 1");
    end
    if (RESET_CYCLES < 1) begin : g_bad_reset
        $fatal(1, "RESET_CYCLES must be at least 1");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $fatal(1, "STABLE_CYCLES must be at least 1");
    end

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_ch
        watchdog_channel #(
            .WAIT_CYCLES   (WAIT_CYCLES),
            .RESET_CYCLES  (RESET_CYCLES),
            .HOLDOFF_CYCLES(HOLDOFF_CYCLES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .MAX_RETRIES   (MAX_RETRIES)
        ) u_ch (
            .clk_i   (clk_i),
            .reset_ni(reset_ni),
            .enable_i(enable_i[i]),
            .error_i (error_i[i]),
            .clear_i (clear_i[i]),
            .reset_o (reset_o[i]),
            .fault_o (fault_o[i])
        );
    end

    // Aggregates are a second register stage, lagging the channel outputs by one cycle.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            any_reset_o <= 1'b1;
            any_fault_o <= 1'b0;
        end else begin
            any_reset_o <= |reset_o;
            any_fault_o <= |fault_o;
        end
    end

endmodule
